operand_fwd_ctrl: RTL and testbench

- Consumer side of the pipeline's hazard-detection path. Takes the 2-bit per-operand hazard selects and resolves them into EX-stage operands.
- Registers the forwarded rs1/rs2 operands into EX.
- Runs a load-use interlock FSM: stalls IF/ID, injects EX bubbles, captures returning load data and replays it into the dependent operand.
- Keeps a saturating stall counter for performance monitoring.

---
 rtl/operand_fwd_ctrl_if.sv | 43 ++++
 rtl/operand_fwd_ctrl.sv | 164 ++++++++++++++++
 tb/tb_operand_fwd_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fwd_ctrl_if.sv
// Operand forwarding bus: ID-stage sources, hazard selects, candidate data,
// writeback/EX-load status (driven by the pipeline) and the registered
// EX operands plus stall/bubble/perf-counter outputs (driven by the block).
//   slave  : operand_fwd_ctrl side
//   master : pipeline / driver side
interface operand_fwd_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             flush;
  logic             id_valid;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic [1:0]       rs1_hz;
  logic [1:0]       rs2_hz;
  logic [31:0]      rf_rs1_data;
  logic [31:0]      rf_rs2_data;
  logic [31:0]      alu_result;
  logic [31:0]      wb_data;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic             ex_is_load;
  logic [4:0]       ex_wr_addr;
  logic [31:0]      op1;
  logic [31:0]      op2;
  logic             op_valid;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  flush, id_valid, id_rs1_addr, id_rs2_addr, rs1_hz, rs2_hz,
           rf_rs1_data, rf_rs2_data, alu_result, wb_data, wb_valid, wb_addr,
           ex_is_load, ex_wr_addr,
    output op1, op2, op_valid, stall, bubble, stall_cnt
  );

  modport master (
    output flush, id_valid, id_rs1_addr, id_rs2_addr, rs1_hz, rs2_hz,
           rf_rs1_data, rf_rs2_data, alu_result, wb_data, wb_valid, wb_addr,
           ex_is_load, ex_wr_addr,
    input  op1, op2, op_valid, stall, bubble, stall_cnt
  );
endinterface

// File: rtl/operand_fwd_ctrl.sv
// EX operand forwarding and load-use interlock.
// Resolves per-operand hazard selects into registered EX operands, stalls
// IF/ID and bubbles EX for LOAD_LAT cycles on a load-use hazard, captures the
// returning load data and replays it into the dependent operand(s).
// Ports: clk, rstn (async active-low), bus (operand_fwd_ctrl_if.slave).
//   stall/bubble are combinational; op1/op2/op_valid/stall_cnt are registered.
module operand_fwd_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input logic               clk,
  input logic               rstn,
  operand_fwd_ctrl_if.slave bus
);

  localparam int unsigned LAT_W = 3;
  // The detect cycle is itself a stall cycle, so WAIT covers the remaining
  // LOAD_LAT-1 cycles; with LOAD_LAT=1 the interlock goes straight to REPLAY.
  localparam logic [LAT_W-1:0] WAIT_INIT = LAT_W'((LOAD_LAT >= 2) ? (LOAD_LAT - 2) : 0);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPLAY = 2'd2
  } state_e;

  localparam state_e HIT_NEXT = (LOAD_LAT <= 1) ? ST_REPLAY : ST_WAIT;

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       pend_q, pend_d;
  logic             m1_q, m1_d, m2_q, m2_d;
  logic [31:0]      rpl_q, rpl_d;
  logic [31:0]      op1_q, op1_d, op2_q, op2_d;
  logic             opv_q, opv_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             stall_c;

  logic             eq1, eq2, lu_hit, wb_hit;
  logic [31:0]      rpl_val, sel1, sel2;

  function automatic logic [31:0] pick(input logic [1:0]  hz,
                                       input logic [31:0] rf,
                                       input logic [31:0] alu,
                                       input logic [31:0] wb);
    logic [31:0] v;
    case (hz)
      2'b01:   v = alu;
      2'b10:   v = wb;
      default: v = rf;
    endcase
    return v;
  endfunction

  // Hazard detect and operand select (replay overrides forwarding, x0 overrides all)
  always_comb begin
    eq1     = (bus.ex_wr_addr == bus.id_rs1_addr);
    eq2     = (bus.ex_wr_addr == bus.id_rs2_addr);
    lu_hit  = bus.id_valid & bus.ex_is_load & (bus.ex_wr_addr != 5'd0) & (eq1 | eq2);
    wb_hit  = bus.wb_valid & (bus.wb_addr == pend_q);
    rpl_val = wb_hit ? bus.wb_data : rpl_q;

    sel1 = pick(bus.rs1_hz, bus.rf_rs1_data, bus.alu_result, bus.wb_data);
    sel2 = pick(bus.rs2_hz, bus.rf_rs2_data, bus.alu_result, bus.wb_data);
    if ((state_q == ST_REPLAY) && m1_q) sel1 = rpl_val;
    if ((state_q == ST_REPLAY) && m2_q) sel2 = rpl_val;
    if (bus.id_rs1_addr == 5'd0) sel1 = '0;
    if (bus.id_rs2_addr == 5'd0) sel2 = '0;
  end

  // Interlock FSM next-state and register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    rpl_d   = rpl_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opv_d   = opv_q;
    stall_c = 1'b0;

    if (bus.flush) begin
      state_d = ST_RUN;
      opv_d   = 1'b0;
      cnt_d   = '0;
      m1_d    = 1'b0;
      m2_d    = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (lu_hit) begin
            stall_c = 1'b1;
            opv_d   = 1'b0;
            pend_d  = bus.ex_wr_addr;
            m1_d    = eq1;
            m2_d    = eq2;
            cnt_d   = WAIT_INIT;
            state_d = HIT_NEXT;
          end else begin
            op1_d = sel1;
            op2_d = sel2;
            opv_d = bus.id_valid;
          end
        end
        ST_WAIT: begin
          stall_c = 1'b1;
          opv_d   = 1'b0;
          if (wb_hit) rpl_d = bus.wb_data;
          if (cnt_q == '0) state_d = ST_REPLAY;
          else             cnt_d   = cnt_q - LAT_W'(1);
        end
        ST_REPLAY: begin
          op1_d   = sel1;
          op2_d   = sel2;
          opv_d   = bus.id_valid;
          state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end

    // Saturating performance counter of stalled cycles
    scnt_d = scnt_q;
    if (stall_c && (scnt_q != '1)) scnt_d = scnt_q + CNT_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pend_q  <= '0;
      m1_q    <= 1'b0;
      m2_q    <= 1'b0;
      rpl_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      opv_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      rpl_q   <= rpl_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opv_q   <= opv_d;
      scnt_q  <= scnt_d;
    end
  end

  // stall/bubble are forced low while reset is asserted
  assign bus.stall     = stall_c & rstn;
  assign bus.bubble    = stall_c & rstn;
  assign bus.op1       = op1_q;
  assign bus.op2       = op2_q;
  assign bus.op_valid  = opv_q;
  assign bus.stall_cnt = scnt_q;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Bench for operand_fwd_ctrl: two instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) share one stimulus stream; a stall-budget model checks
// every cycle, and directed phases pin literal values.
module tb_operand_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush, id_valid, wb_valid, ex_is_load;
  logic [4:0]  rs1a, rs2a, wb_addr, ex_wr;
  logic [1:0]  hz1, hz2;
  logic [31:0] rf1, rf2, alu, wbd;

  always #5 clk = ~clk;

  operand_fwd_ctrl_if #(.CNT_W(16)) ifa ();
  operand_fwd_ctrl_if #(.CNT_W(4))  ifb ();

  assign ifa.flush = flush;        assign ifb.flush = flush;
  assign ifa.id_valid = id_valid;  assign ifb.id_valid = id_valid;
  assign ifa.id_rs1_addr = rs1a;   assign ifb.id_rs1_addr = rs1a;
  assign ifa.id_rs2_addr = rs2a;   assign ifb.id_rs2_addr = rs2a;
  assign ifa.rs1_hz = hz1;         assign ifb.rs1_hz = hz1;
  assign ifa.rs2_hz = hz2;         assign ifb.rs2_hz = hz2;
  assign ifa.rf_rs1_data = rf1;    assign ifb.rf_rs1_data = rf1;
  assign ifa.rf_rs2_data = rf2;    assign ifb.rf_rs2_data = rf2;
  assign ifa.alu_result = alu;     assign ifb.alu_result = alu;
  assign ifa.wb_data = wbd;        assign ifb.wb_data = wbd;
  assign ifa.wb_valid = wb_valid;  assign ifb.wb_valid = wb_valid;
  assign ifa.wb_addr = wb_addr;    assign ifb.wb_addr = wb_addr;
  assign ifa.ex_is_load = ex_is_load; assign ifb.ex_is_load = ex_is_load;
  assign ifa.ex_wr_addr = ex_wr;   assign ifb.ex_wr_addr = ex_wr;

  operand_fwd_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
  operand_fwd_ctrl #(.LOAD_LAT(3), .CNT_W(4))  dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

  int n_pass = 0;
  int n_tot  = 0;

  // Model: per instance, stall cycles still owed, pending replay, captured load data
  int unsigned lat[2]  = '{1, 3};
  int unsigned cmax[2] = '{65535, 15};
  int          owe[2];
  bit          rp[2], mm1[2], mm2[2];
  logic [4:0]  pa[2];
  logic [31:0] cap[2], e_op1[2], e_op2[2];
  bit          e_opv[2];
  int unsigned e_cnt[2];
  logic        st_seen[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owe[k] = 0; rp[k] = 0; mm1[k] = 0; mm2[k] = 0; pa[k] = '0; cap[k] = '0;
      e_op1[k] = '0; e_op2[k] = '0; e_opv[k] = 0; e_cnt[k] = 0;
    end
  endtask

  function automatic bit load_use();
    return id_valid && ex_is_load && (ex_wr != 5'd0) && ((ex_wr == rs1a) || (ex_wr == rs2a));
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] hz, input logic [31:0] rf);
    if (hz == 2'b01) return alu;
    if (hz == 2'b10) return wbd;
    return rf;
  endfunction

  function automatic bit exp_stall(input int k);
    if (flush) return 0;
    if (owe[k] > 0) return 1;
    if (rp[k]) return 0;
    return load_use();
  endfunction

  task automatic model_step(input int k);
    bit s;
    logic [31:0] r, v1, v2;
    s  = exp_stall(k);
    v1 = fwd(hz1, rf1);
    v2 = fwd(hz2, rf2);
    if (flush) begin
      e_opv[k] = 0; owe[k] = 0; rp[k] = 0; mm1[k] = 0; mm2[k] = 0;
    end else if (owe[k] > 0) begin
      if (wb_valid && wb_addr == pa[k]) cap[k] = wbd;
      e_opv[k] = 0;
      owe[k]--;
      if (owe[k] == 0) rp[k] = 1;
    end else if (rp[k]) begin
      r = (wb_valid && wb_addr == pa[k]) ? wbd : cap[k];
      if (mm1[k]) v1 = r;
      if (mm2[k]) v2 = r;
      e_op1[k] = (rs1a == 5'd0) ? 32'd0 : v1;
      e_op2[k] = (rs2a == 5'd0) ? 32'd0 : v2;
      e_opv[k] = id_valid;
      rp[k] = 0;
    end else if (load_use()) begin
      pa[k] = ex_wr; mm1[k] = (ex_wr == rs1a); mm2[k] = (ex_wr == rs2a);
      owe[k] = int'(lat[k]) - 1;
      rp[k] = (owe[k] == 0);
      e_opv[k] = 0;
    end else begin
      e_op1[k] = (rs1a == 5'd0) ? 32'd0 : v1;
      e_op2[k] = (rs2a == 5'd0) ? 32'd0 : v2;
      e_opv[k] = id_valid;
    end
    if (s && e_cnt[k] < cmax[k]) e_cnt[k]++;
  endtask

  // One clock: check combinational outputs mid-cycle, registered ones after the edge
  task automatic cycle();
    @(negedge clk);
    st_seen[0] = ifa.stall;
    st_seen[1] = ifb.stall;
    chk("stall_a",  32'(ifa.stall),  32'(exp_stall(0)));
    chk("bubble_a", 32'(ifa.bubble), 32'(exp_stall(0)));
    chk("stall_b",  32'(ifb.stall),  32'(exp_stall(1)));
    chk("bubble_b", 32'(ifb.bubble), 32'(exp_stall(1)));
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk("op1_a", ifa.op1, e_op1[0]);
    chk("op2_a", ifa.op2, e_op2[0]);
    chk("opv_a", 32'(ifa.op_valid), 32'(e_opv[0]));
    chk("cnt_a", 32'(ifa.stall_cnt), e_cnt[0]);
    chk("op1_b", ifb.op1, e_op1[1]);
    chk("op2_b", ifb.op2, e_op2[1]);
    chk("opv_b", 32'(ifb.op_valid), 32'(e_opv[1]));
    chk("cnt_b", 32'(ifb.stall_cnt), e_cnt[1]);
  endtask

  task automatic idle();
    flush = 0; id_valid = 0; wb_valid = 0; ex_is_load = 0;
    rs1a = '0; rs2a = '0; wb_addr = '0; ex_wr = '0; hz1 = '0; hz2 = '0;
    rf1 = '0; rf2 = '0; alu = '0; wbd = '0;
  endtask

  initial begin
    rstn = 1'b1;
    idle();
    model_reset();
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op1_a", ifa.op1, 32'h0);
    chk("rst_opv_a", 32'(ifa.op_valid), 32'h0);
    chk("rst_cnt_b", 32'(ifb.stall_cnt), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Forwarding selects
    id_valid = 1; rs1a = 5'd3; hz1 = 2'b01; alu = 32'h0000_1234; rf1 = 32'hDEAD_BEEF;
    rs2a = 5'd4; hz2 = 2'b00; rf2 = 32'h1111_1111;
    cycle();
    chk("ex_fwd_op1", ifa.op1, 32'h0000_1234);
    chk("ex_fwd_vld", 32'(ifa.op_valid), 32'h1);
    hz2 = 2'b10; wbd = 32'hCAFE_0001;
    cycle();
    chk("wb_fwd_op2", ifa.op2, 32'hCAFE_0001);
    hz2 = 2'b11; rf2 = 32'h0000_0055;
    cycle();
    chk("rsv_rf_op2", ifa.op2, 32'h0000_0055);
    rs1a = 5'd0; hz1 = 2'b01;
    cycle();
    chk("x0_op1", ifa.op1, 32'h0);

    // Load-use on rs1, load data returns the following cycle
    rs1a = 5'd5; rs2a = 5'd6; hz1 = 2'b00; hz2 = 2'b00; ex_is_load = 1; ex_wr = 5'd5;
    cycle();
    chk("lu_stall_a", 32'(st_seen[0]), 32'h1);
    chk("lu_opv_a", 32'(ifa.op_valid), 32'h0);
    ex_is_load = 0; wb_valid = 1; wb_addr = 5'd5; wbd = 32'hA5A5_A5A5;
    cycle();
    chk("lu_one_stall_a", 32'(st_seen[0]), 32'h0);
    chk("lu_replay_a", ifa.op1, 32'hA5A5_A5A5);
    chk("lu_cnt_a", 32'(ifa.stall_cnt), 32'h1);
    wb_valid = 0;
    cycle();
    cycle();
    chk("lu3_replay_b", ifb.op1, 32'hA5A5_A5A5);
    chk("lu3_cnt_b", 32'(ifb.stall_cnt), 32'h3);

    // Both operands depend on one load
    rs1a = 5'd7; rs2a = 5'd7; ex_wr = 5'd7; ex_is_load = 1;
    cycle();
    ex_is_load = 0; wb_valid = 1; wb_addr = 5'd7; wbd = 32'h1357_9BDF;
    cycle();
    chk("both_op1_a", ifa.op1, 32'h1357_9BDF);
    chk("both_op2_a", ifa.op2, 32'h1357_9BDF);
    wb_valid = 0; wbd = 32'h0;
    cycle();
    cycle();
    chk("both_op1_b", ifb.op1, 32'h1357_9BDF);
    chk("both_op2_b", ifb.op2, 32'h1357_9BDF);
    chk("both_cnt_b", 32'(ifb.stall_cnt), 32'h6);
    chk("both_cnt_a", 32'(ifa.stall_cnt), 32'h2);

    // Flush while B waits: no replay afterwards
    rs1a = 5'd9; rs2a = 5'd2; ex_wr = 5'd9; ex_is_load = 1;
    cycle();
    ex_is_load = 0; flush = 1; wb_valid = 1; wb_addr = 5'd9; wbd = 32'hFFFF_0000;
    cycle();
    chk("flush_stall_b", 32'(st_seen[1]), 32'h0);
    chk("flush_opv_b", 32'(ifb.op_valid), 32'h0);
    chk("flush_opv_a", 32'(ifa.op_valid), 32'h0);
    flush = 0; wb_valid = 0;
    cycle();
    chk("flush_norpl_b", ifb.op1, 32'hDEAD_BEEF);
    chk("flush_cnt_b", 32'(ifb.stall_cnt), 32'h7);

    // Flush coinciding with a load-use hazard
    ex_is_load = 1; flush = 1;
    cycle();
    chk("flush_hit_a", 32'(st_seen[0]), 32'h0);
    chk("flush_hit_b", 32'(st_seen[1]), 32'h0);
    flush = 0; ex_is_load = 0;
    cycle();

    // Asynchronous reset while B is in the middle of its wait
    ex_is_load = 1; ex_wr = 5'd5; rs1a = 5'd5;
    cycle();
    cycle();
    #2 rstn = 1'b0;
    #1;
    chk("rstw_op1_b", ifb.op1, 32'h0);
    chk("rstw_op2_b", ifb.op2, 32'h0);
    chk("rstw_opv_b", 32'(ifb.op_valid), 32'h0);
    chk("rstw_stall_b", 32'(ifb.stall), 32'h0);
    chk("rstw_cnt_b", 32'(ifb.stall_cnt), 32'h0);
    model_reset();
    ex_is_load = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    // Drive B's 4-bit counter past saturation
    for (int i = 0; i < 6; i++) begin
      ex_is_load = 1; ex_wr = 5'd5; rs1a = 5'd5; id_valid = 1;
      cycle();
      ex_is_load = 0;
      repeat (3) cycle();
    end
    chk("sat_cnt_b", 32'(ifb.stall_cnt), 32'hF);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      flush      = ($urandom_range(0, 19) == 0);
      id_valid   = ($urandom_range(0, 9) != 0);
      rs1a       = 5'($urandom_range(0, 7));
      rs2a       = 5'($urandom_range(0, 7));
      hz1        = 2'($urandom_range(0, 3));
      hz2        = 2'($urandom_range(0, 3));
      rf1        = $urandom;
      rf2        = $urandom;
      alu        = $urandom;
      wbd        = $urandom;
      wb_valid   = ($urandom_range(0, 1) == 1);
      wb_addr    = 5'($urandom_range(0, 7));
      ex_is_load = ($urandom_range(0, 2) == 0);
      ex_wr      = 5'($urandom_range(0, 7));
      cycle();
    end
    chk("sat_hold_b", 32'(ifb.stall_cnt), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
